scanline_scheduler: RTL and testbench

Double-buffered scanline controller feeding the VGA timing block's `color_in` bus. It tracks the display line sequence from `vga_vs` and `next_line`, and issues one render request per line to the pixel renderer over a valid/ready handshake. It captures the renderer's pixel writes into a back buffer and swaps back and front buffers during each horizontal back porch. Lines the renderer fails to finish in time are aborted and counted as underruns.

---
 rtl/scanline_scheduler_pkg.sv | 24 ++
 rtl/scanline_scheduler_line_buffer.sv | 34 +++
 rtl/scanline_scheduler.sv | 143 ++++++++++++++
 tb/tb_scanline_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scanline_scheduler_pkg.sv
// Types: shared pixel type, display geometry and scheduler FSM states
// used by the scanline scheduler and its line buffers.
package Types;

   typedef logic [11:0] Color;

   localparam int H_PIXELS     = 640;
   localparam int V_LINES      = 480;
   localparam int V_BACK_LINES = 33;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      BUSY,
      FULL
   } sched_state_t;

   // Swap event n (1-based) precedes display line n - V_BACK_LINES.
   localparam logic [9:0] FIRST_SWAP_EV = 10'(V_BACK_LINES);
   localparam logic [9:0] LAST_SWAP_EV  = 10'(V_BACK_LINES + V_LINES - 1);
   localparam logic [9:0] Y_OFFSET      = 10'(V_BACK_LINES - 1);
   localparam logic [9:0] X_LIMIT       = 10'(H_PIXELS);

endpackage

// File: rtl/scanline_scheduler_line_buffer.sv
// line_buffer: one scanline of pixels with a single write port,
// synchronous clear and a full parallel read bus.
module line_buffer
   import Types::*;
(
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 we,
   input  logic [9:0]           x,
   input  Color                 color,
   output Color [H_PIXELS-1:0]  pixels
);

   Color [H_PIXELS-1:0] mem_q;
   Color [H_PIXELS-1:0] mem_d;

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[x] = color;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign pixels = mem_q;

endmodule

// File: rtl/scanline_scheduler.sv
// scanline_scheduler: double-buffered scanline controller with render request FSM.
// Optional saturating underrun counter enabled by SCHED_UNDERRUN_CNT_EN.
module scanline_scheduler
   import Types::*;
(
   input  logic                 CLK25MHZ,
   input  logic                 ck_rst,
   input  logic                 vga_vs,
   input  logic                 next_line,
   output logic                 rq_valid,
   output logic [8:0]           rq_y,
   input  logic                 rq_ready,
   output logic                 rq_abort,
   input  logic                 px_we,
   input  logic [9:0]           px_x,
   input  Color                 px_color,
   input  logic                 rd_done,
   output Color [H_PIXELS-1:0]  color_out
`ifdef SCHED_UNDERRUN_CNT_EN
   ,
   output logic [15:0]          underrun_cnt
`endif
);

   logic          vs_s_q, vs_d_q, nl_s_q, nl_d_q;
   logic          vs_rise, swap_ev, swap_ok, last_line, wr_en;
   logic [9:0]    ev_cnt_q, ev_cnt_d, ev_inc;
   logic [8:0]    next_y, rq_y_q, rq_y_d;
   sched_state_t  state_q, state_d;
   logic          sel_q, sel_d, rq_valid_q, rq_valid_d, abort_q, abort_d;
   Color [H_PIXELS-1:0] buf0_px, buf1_px;

   assign vs_rise   = vs_s_q & ~vs_d_q;
   assign swap_ev   = nl_d_q & ~nl_s_q;
   assign ev_inc    = (ev_cnt_q == 10'h3FF) ? ev_cnt_q : ev_cnt_q + 10'd1;
   assign swap_ok   = swap_ev && (ev_inc >= FIRST_SWAP_EV) && (ev_inc <= LAST_SWAP_EV);
   assign last_line = (ev_inc == LAST_SWAP_EV);
   assign next_y    = 9'(ev_inc - Y_OFFSET);
   assign wr_en     = (state_q == BUSY) && px_we && (px_x < X_LIMIT);

   // A late renderer (swap before rd_done, or vsync outside IDLE) aborts and discards the back buffer.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      rq_y_d   = rq_y_q;
      abort_d  = 1'b0;
      ev_cnt_d = vs_rise ? 10'd0 : (swap_ev ? ev_inc : ev_cnt_q);
      if (vs_rise) begin
         state_d = REQ;
         rq_y_d  = '0;
         abort_d = (state_q != IDLE);
      end else if (swap_ok) begin
         if ((state_q == FULL) || ((state_q == BUSY) && rd_done)) begin
            sel_d = ~sel_q;
         end else if (state_q != IDLE) begin
            abort_d = 1'b1;
         end
         if (last_line) begin
            state_d = IDLE;
         end else begin
            state_d = REQ;
            rq_y_d  = next_y;
         end
      end else if ((state_q == REQ) && rq_ready) begin
         state_d = BUSY;
      end else if ((state_q == BUSY) && rd_done) begin
         state_d = FULL;
      end
      rq_valid_d = (state_d == REQ);
   end

   always_ff @(posedge CLK25MHZ) begin
      if (ck_rst) begin
         vs_s_q     <= 1'b1;
         vs_d_q     <= 1'b1;
         nl_s_q     <= 1'b0;
         nl_d_q     <= 1'b0;
         ev_cnt_q   <= '0;
         state_q    <= IDLE;
         sel_q      <= 1'b0;
         rq_y_q     <= '0;
         rq_valid_q <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         vs_s_q     <= vga_vs;
         vs_d_q     <= vs_s_q;
         nl_s_q     <= next_line;
         nl_d_q     <= nl_s_q;
         ev_cnt_q   <= ev_cnt_d;
         state_q    <= state_d;
         sel_q      <= sel_d;
         rq_y_q     <= rq_y_d;
         rq_valid_q <= rq_valid_d;
         abort_q    <= abort_d;
      end
   end

   // sel_q = 0 shows buf0 and renders into buf1; sel_q = 1 is the reverse.
   line_buffer u_buf0 (
      .clk    (CLK25MHZ),
      .clr    (ck_rst | (abort_d & sel_q)),
      .we     (wr_en & sel_q),
      .x      (px_x),
      .color  (px_color),
      .pixels (buf0_px)
   );

   line_buffer u_buf1 (
      .clk    (CLK25MHZ),
      .clr    (ck_rst | (abort_d & ~sel_q)),
      .we     (wr_en & ~sel_q),
      .x      (px_x),
      .color  (px_color),
      .pixels (buf1_px)
   );

   assign color_out = sel_q ? buf1_px : buf0_px;
   assign rq_valid  = rq_valid_q;
   assign rq_y      = rq_y_q;
   assign rq_abort  = abort_q;

`ifdef SCHED_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt_q, underrun_cnt_d;

   always_comb begin
      underrun_cnt_d = underrun_cnt_q;
      if (abort_d && (underrun_cnt_q != 16'hFFFF)) begin
         underrun_cnt_d = underrun_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge CLK25MHZ) begin
      if (ck_rst) begin
         underrun_cnt_q <= '0;
      end else begin
         underrun_cnt_q <= underrun_cnt_d;
      end
   end

   assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_scanline_scheduler.sv
// Directed testbench for scanline_scheduler: reset, first frame, full on-time
// frame, underrun, coincident rd_done/swap, out-of-range writes and mid-frame reset.
module tb_scanline_scheduler;
   import Types::*;

   logic                clock     = 1'b0;
   logic                reset     = 1'b1;
   logic                vga_vs    = 1'b1;
   logic                next_line = 1'b1;
   logic                rq_ready  = 1'b0;
   logic                px_we     = 1'b0;
   logic                rd_done   = 1'b0;
   logic [9:0]          px_x      = '0;
   Color                px_color  = '0;
   logic                rq_valid, rq_abort;
   logic [8:0]          rq_y;
   Color [H_PIXELS-1:0] color_out;
`ifdef SCHED_UNDERRUN_CNT_EN
   logic [15:0]         underrun_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #20 clock = ~clock;

   scanline_scheduler dut (
      .CLK25MHZ  (clock),
      .ck_rst    (reset),
      .vga_vs    (vga_vs),
      .next_line (next_line),
      .rq_valid  (rq_valid),
      .rq_y      (rq_y),
      .rq_ready  (rq_ready),
      .rq_abort  (rq_abort),
      .px_we     (px_we),
      .px_x      (px_x),
      .px_color  (px_color),
      .rd_done   (rd_done),
      .color_out (color_out)
`ifdef SCHED_UNDERRUN_CNT_EN
      ,
      .underrun_cnt (underrun_cnt)
`endif
   );

   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic vsPulse();
      vga_vs = 1'b0;
      applyStimulus(1);
      vga_vs = 1'b1;
      applyStimulus(2);
   endtask

   task automatic lineFall();
      next_line = 1'b0;
      applyStimulus(1);
      next_line = 1'b1;
      applyStimulus(1);
   endtask

   // Accept the pending request, write pixels 0 and 639, optionally finish the line.
   task automatic renderLine(input Color color, input bit done);
      int guard;
      guard = 0;
      while (rq_valid !== 1'b1 && guard < 50) begin
         applyStimulus(1);
         guard++;
      end
      checkOutput("reqSeen", 32'(rq_valid), 32'd1);
      rq_ready = 1'b1;
      applyStimulus(1);
      rq_ready = 1'b0;
      px_we    = 1'b1;
      px_color = color;
      px_x     = 10'd0;
      applyStimulus(1);
      px_x     = 10'd639;
      applyStimulus(1);
      px_we    = 1'b0;
      if (done) begin
         rd_done = 1'b1;
         applyStimulus(1);
         rd_done = 1'b0;
      end
   endtask

   initial begin
      $display("[TB] start");
      applyStimulus(2);
      reset = 1'b0;
      checkOutput("resetValid", 32'(rq_valid), 32'd0);
      checkOutput("resetY", 32'(rq_y), 32'd0);
      checkOutput("resetAbort", 32'(rq_abort), 32'd0);
      checkOutput("resetColor", 32'(color_out === '0), 32'd1);
`ifdef SCHED_UNDERRUN_CNT_EN
      checkOutput("resetUnderrun", 32'(underrun_cnt), 32'd0);
`endif
      applyStimulus(1);

      vga_vs = 1'b0;
      applyStimulus(1);
      vga_vs = 1'b1;
      applyStimulus(1);
      checkOutput("vsEarly", 32'(rq_valid), 32'd0);
      applyStimulus(1);
      checkOutput("vsValid", 32'(rq_valid), 32'd1);
      checkOutput("vsY", 32'(rq_y), 32'd0);
      checkOutput("vsColorZero", 32'(color_out === '0), 32'd1);

      rq_ready = 1'b1;
      applyStimulus(1);
      rq_ready = 1'b0;
      px_we    = 1'b1;
      px_color = 12'hF00;
      px_x     = 10'd0;
      applyStimulus(1);
      px_x     = 10'd1;
      applyStimulus(1);
      px_x     = 10'd639;
      applyStimulus(1);
      px_we    = 1'b0;
      rd_done  = 1'b1;
      applyStimulus(1);
      rd_done  = 1'b0;

      repeat (32) lineFall();
      checkOutput("porchFront", 32'(color_out[0]), 32'h000);
      checkOutput("porchValid", 32'(rq_valid), 32'd0);
      lineFall();
      checkOutput("line0Px0", 32'(color_out[0]), 32'hF00);
      checkOutput("line0Px1", 32'(color_out[1]), 32'hF00);
      checkOutput("line0NextY", 32'(rq_y), 32'd1);
      checkOutput("line0NextValid", 32'(rq_valid), 32'd1);

      for (int k = 1; k < 480; k++) begin
         renderLine(12'(k), 1'b1);
         lineFall();
         checkOutput("frameFront0", 32'(color_out[0]), 32'(k));
         checkOutput("frameFront639", 32'(color_out[639]), 32'(k));
         if (k < 479) begin
            checkOutput("frameNextY", 32'(rq_y), 32'(k + 1));
         end else begin
            checkOutput("frameEndIdle", 32'(rq_valid), 32'd0);
         end
      end
      repeat (3) lineFall();
      checkOutput("afterFrameValid", 32'(rq_valid), 32'd0);
      checkOutput("afterFrameFront", 32'(color_out[0]), 32'd479);

      vsPulse();
      checkOutput("frameBValid", 32'(rq_valid), 32'd1);
      checkOutput("frameBY", 32'(rq_y), 32'd0);
      checkOutput("frameBNoAbort", 32'(rq_abort), 32'd0);
      renderLine(12'hA00, 1'b1);
      repeat (32) lineFall();
      for (int k = 0; k < 5; k++) begin
         lineFall();
         checkOutput("bFront0", 32'(color_out[0]), 32'(12'hA00 + k));
         checkOutput("bFullWriteIgnored", 32'(color_out[2]), 32'd0);
         checkOutput("bNextY", 32'(rq_y), 32'(k + 1));
         if (k == 0) begin
            renderLine(12'hA01, 1'b1);
            px_we    = 1'b1;
            px_x     = 10'd2;
            px_color = 12'hFFF;
            applyStimulus(1);
            px_we    = 1'b0;
         end else if (k < 4) begin
            renderLine(12'(12'hA00 + k + 1), 1'b1);
         end else begin
            renderLine(12'hA05, 1'b0);
         end
      end

      lineFall();
      checkOutput("underrunAbort", 32'(rq_abort), 32'd1);
      checkOutput("underrunFront", 32'(color_out[0]), 32'hA04);
      checkOutput("underrunNextY", 32'(rq_y), 32'd6);
      checkOutput("underrunValid", 32'(rq_valid), 32'd1);
`ifdef SCHED_UNDERRUN_CNT_EN
      checkOutput("underrunCount", 32'(underrun_cnt), 32'd1);
`endif
      applyStimulus(1);
      checkOutput("underrunAbortOnce", 32'(rq_abort), 32'd0);

      rq_ready = 1'b1;
      applyStimulus(1);
      rq_ready = 1'b0;
      px_we    = 1'b1;
      px_x     = 10'd639;
      px_color = 12'hA06;
      applyStimulus(1);
      px_x     = 10'd640;
      px_color = 12'hFFF;
      applyStimulus(1);
      px_we     = 1'b0;
      next_line = 1'b0;
      applyStimulus(1);
      rd_done   = 1'b1;
      next_line = 1'b1;
      applyStimulus(1);
      rd_done   = 1'b0;
      checkOutput("coincNoAbort", 32'(rq_abort), 32'd0);
      checkOutput("coincFront639", 32'(color_out[639]), 32'hA06);
      checkOutput("coincDiscarded", 32'(color_out[0]), 32'd0);
      checkOutput("coincNextY", 32'(rq_y), 32'd7);
      checkOutput("coincValid", 32'(rq_valid), 32'd1);
`ifdef SCHED_UNDERRUN_CNT_EN
      checkOutput("coincCount", 32'(underrun_cnt), 32'd1);
`endif

      rq_ready = 1'b1;
      applyStimulus(1);
      rq_ready = 1'b0;
      px_we    = 1'b1;
      px_x     = 10'd0;
      px_color = 12'h123;
      applyStimulus(1);
      px_we = 1'b0;
      reset = 1'b1;
      applyStimulus(1);
      reset = 1'b0;
      checkOutput("midResetValid", 32'(rq_valid), 32'd0);
      checkOutput("midResetY", 32'(rq_y), 32'd0);
      checkOutput("midResetAbort", 32'(rq_abort), 32'd0);
      checkOutput("midResetColor", 32'(color_out === '0), 32'd1);
`ifdef SCHED_UNDERRUN_CNT_EN
      checkOutput("midResetCount", 32'(underrun_cnt), 32'd0);
`endif

      vsPulse();
      checkOutput("idleVsAbort", 32'(rq_abort), 32'd0);
      checkOutput("idleVsValid", 32'(rq_valid), 32'd1);
      vsPulse();
      checkOutput("lateVsAbort", 32'(rq_abort), 32'd1);
      checkOutput("lateVsY", 32'(rq_y), 32'd0);
      checkOutput("lateVsValid", 32'(rq_valid), 32'd1);
`ifdef SCHED_UNDERRUN_CNT_EN
      checkOutput("lateVsCount", 32'(underrun_cnt), 32'd1);
`endif
      applyStimulus(1);
      checkOutput("lateVsAbortOnce", 32'(rq_abort), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
